pds_bus_master: RTL and testbench
=================================

PDS_BUS_MASTER -- requirements
Module: pds_bus_master

Interface
REQ-001 Parameters SHALL be: TIMEOUT, default 64, WAIT-state C16M cycles before forced termination (legal range 8..2^TOW-1); TOW, default 8, timeout counter width; VMA_SLOT, default 7, E-phase count at which nVMA asserts; ETACK_SLOT, default 16, E-phase count that acknowledges a VPA cycle.
REQ-002 Ports SHALL be, clock and reset first: C16M in 1 sole clock; RST in 1 reset, asynchronous, active-high.
REQ-003 IOREQ in 1 transfer request; IOWE in 1 write; IOLDS in 1 low byte; IOUDS in 1 high byte; nADLEEN in 1 external latch-enable override, active low.
REQ-004 IOACT out 1 transfer active; IOERR out 1 last transfer ended by bus error or timeout.
REQ-005 C8M out 1 generated CPU clock; E out 1 generated 6800 E clock.
REQ-006 nAS, nLDS, nUDS, nVMA out 1 each, active-low bus strobes; nDTACK, nVPA, nBERR in 1 each, active-low bus responses.
REQ-007 nAoutOE, nDoutOE, nADoutLE, nDinLE out 1 each, active-low latch controls.

Function
REQ-008 All registers SHALL update on rising C16M only; nADoutLE is the only combinational output, equal to NOT(ADoutLE OR NOT nADLEEN); nAoutOE SHALL be constant 0.
REQ-009 C8M SHALL toggle every C16M cycle (C16M/2).
REQ-010 ECNT SHALL count 0..19 in C16M cycles, wrapping 19->0; E SHALL be 1 when ECNT is 12..19, else 0 (6 CPU clocks low, 4 high).
REQ-011 IOREQ SHALL pass through one synchronizer flop (IOREQr) before use.
REQ-012 States SHALL be IDLE, S1, S2, S3, S4, WAIT, TERM, REC.
REQ-013 IDLE: if IOREQr=1, IOACT<=1 and ADoutLE<=1; go to S1 only when C8M=0, otherwise stay in IDLE; if IOREQr=0, IOACT<=0 and ADoutLE<=0.
REQ-014 S1->S2->S3->S4->WAIT SHALL be unconditional, one cycle each, IOACT=1 and ADoutLE=1 throughout.
REQ-015 WAIT SHALL exit to TERM when C8M=1 and any of: nDTACK=0, ETACK=1, nBERR=0, or timeout counter equals TIMEOUT; IOACT<=0 on exit.
REQ-016 IOERR SHALL be set on WAIT exit when nBERR=0 or timeout caused the exit, cleared when nDTACK=0 or ETACK caused it; nBERR=0 takes priority over nDTACK=0 in the same cycle; nDTACK=0 or ETACK takes priority over timeout.
REQ-017 IOERR SHALL hold its value until the next IDLE->S1 transition, which clears it.
REQ-018 The timeout counter (TOW bits) SHALL clear outside WAIT, increment every WAIT cycle, and freeze while nVMA=0; it never wraps.
REQ-019 TERM->REC->IDLE SHALL be unconditional; ADoutLE=1 in WAIT, 0 in TERM and REC.
REQ-020 nVMA SHALL go 0 when state=WAIT, nVPA=0 and ECNT=VMA_SLOT; nVMA SHALL return to 1 when ECNT=0.
REQ-021 ETACK SHALL be registered 1 for the cycle after ECNT=ETACK_SLOT with nVMA=0, else 0.
REQ-022 nAS SHALL be 0 in S1..WAIT; nLDS/nUDS SHALL be 0 when IOLDS/IOUDS=1 and (state S1 or S2 with IOWE=0, or state S3, S4, WAIT).
REQ-023 nDoutOE SHALL be 0 when IOWE=1 and state is S1..TERM; nDinLE SHALL be 0 in S4 and WAIT.
REQ-024 IOREQ held high after IOACT falls SHALL start a new transfer from IDLE after REC; no request is dropped or merged.

Reset
REQ-025 RST=1 SHALL force immediately: state IDLE, IOREQr=0, IOACT=0, IOERR=0, ADoutLE=0, C8M=0, ECNT=0, E=0, ETACK=0, timeout=0, nAS=nLDS=nUDS=nVMA=nDoutOE=nDinLE=1.
REQ-026 RST asserted mid-transfer SHALL release all strobes within the same assertion; after deassertion the block SHALL start from IDLE with no residual request.

Verification
REQ-027 Read, IOLDS=IOUDS=1, nDTACK low in WAIT -> nAS/nLDS/nUDS low from S1, IOACT falls on TERM entry, IOERR=0, nDoutOE stays 1.
REQ-028 Write, IOLDS=1 IOUDS=0 -> nLDS low only from S3, nUDS stays 1, nDoutOE low S1..TERM.
REQ-029 nVPA low, no nDTACK -> nVMA low at ECNT=7, ETACK after ECNT=16, termination with IOERR=0, nVMA high at ECNT=0.
REQ-030 nBERR and nDTACK low same cycle -> TERM with IOERR=1; no response at all -> TERM after 64 WAIT cycles, IOERR=1.
REQ-031 RST pulse during WAIT -> all strobes 1, IOACT=0 immediately; IOREQ held high afterward -> clean new transfer.
REQ-032 IOREQ held high continuously -> back-to-back transfers, each passing REC and IDLE, IOACT low at least two cycles between them.

Source files
------------

// File: rtl/pds_bus_master.sv
`timescale 1ns/1ps
// pds_bus_master: 68000-style asynchronous bus cycle sequencer driven from C16M.
// Generates C8M and the 6800 E clock, runs AS/DS strobes through S1..WAIT,
// terminates on DTACK, VPA/E-sync acknowledge, bus error or timeout.
module pds_bus_master #(
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned TOW        = 8,
  parameter int unsigned VMA_SLOT   = 7,
  parameter int unsigned ETACK_SLOT = 16
) (
  input  logic C16M,
  input  logic RST,
  input  logic IOREQ,
  input  logic IOWE,
  input  logic IOLDS,
  input  logic IOUDS,
  input  logic nADLEEN,
  output logic IOACT,
  output logic IOERR,
  output logic C8M,
  output logic E,
  output logic nAS,
  output logic nLDS,
  output logic nUDS,
  output logic nVMA,
  input  logic nDTACK,
  input  logic nVPA,
  input  logic nBERR,
  output logic nAoutOE,
  output logic nDoutOE,
  output logic nADoutLE,
  output logic nDinLE
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_WAIT = 3'd5,
    ST_TERM = 3'd6,
    ST_REC  = 3'd7
  } state_t;

  localparam logic [4:0]     ECNT_LAST = 5'd19;
  localparam logic [4:0]     E_HIGH    = 5'd12;
  localparam logic [4:0]     VMA_E     = 5'(VMA_SLOT);
  localparam logic [4:0]     ETACK_E   = 5'(ETACK_SLOT);
  localparam logic [TOW-1:0] TMO_LIM   = TOW'(TIMEOUT);

  state_t         state_q, state_d;
  logic           ioreq_q;
  logic           ioact_q, ioact_d;
  logic           ioerr_q, ioerr_d;
  logic           adoutle_q, adoutle_d;
  logic           c8m_q;
  logic [4:0]     ecnt_q, ecnt_d;
  logic           e_q;
  logic           etack_q;
  logic [TOW-1:0] tmo_q;
  logic           nvma_q;
  logic           nas_q, nlds_q, nuds_q, ndoutoe_q, ndinle_q;
  logic           nas_d, nlds_d, nuds_d, ndoutoe_d, ndinle_d;
  logic           tmo_hit;
  logic           ack_ok;

  assign tmo_hit = (tmo_q == TMO_LIM);
  assign ack_ok  = !nDTACK || etack_q;
  assign ecnt_d  = (ecnt_q == ECNT_LAST) ? 5'd0 : ecnt_q + 5'd1;

  // Next-state and transfer-status logic of the bus cycle sequencer
  always_comb begin
    state_d   = state_q;
    ioact_d   = ioact_q;
    ioerr_d   = ioerr_q;
    adoutle_d = adoutle_q;
    case (state_q)
      ST_IDLE: begin
        if (ioreq_q) begin
          ioact_d   = 1'b1;
          adoutle_d = 1'b1;
          // Start only on the C8M phase that puts S1 on a high half-clock
          if (!c8m_q) begin
            state_d = ST_S1;
            ioerr_d = 1'b0;
          end
        end else begin
          ioact_d   = 1'b0;
          adoutle_d = 1'b0;
        end
      end
      ST_S1: begin
        state_d   = ST_S2;
        ioact_d   = 1'b1;
        adoutle_d = 1'b1;
      end
      ST_S2: begin
        state_d   = ST_S3;
        ioact_d   = 1'b1;
        adoutle_d = 1'b1;
      end
      ST_S3: begin
        state_d   = ST_S4;
        ioact_d   = 1'b1;
        adoutle_d = 1'b1;
      end
      ST_S4: begin
        state_d   = ST_WAIT;
        ioact_d   = 1'b1;
        adoutle_d = 1'b1;
      end
      ST_WAIT: begin
        adoutle_d = 1'b1;
        if (c8m_q && (ack_ok || !nBERR || tmo_hit)) begin
          state_d   = ST_TERM;
          ioact_d   = 1'b0;
          adoutle_d = 1'b0;
          // Bus error beats a normal acknowledge; an acknowledge beats timeout
          ioerr_d   = !nBERR || !ack_ok;
        end
      end
      ST_TERM: begin
        state_d   = ST_REC;
        adoutle_d = 1'b0;
      end
      ST_REC: begin
        state_d   = ST_IDLE;
        adoutle_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobe decode from the upcoming state so registered strobes line up with it
  always_comb begin
    nas_d     = 1'b1;
    nlds_d    = 1'b1;
    nuds_d    = 1'b1;
    ndoutoe_d = 1'b1;
    ndinle_d  = 1'b1;
    if (state_d inside {ST_S1, ST_S2, ST_S3, ST_S4, ST_WAIT}) begin
      nas_d = 1'b0;
    end
    // Reads drive data strobes from S1, writes wait until data is valid in S3
    if (((state_d inside {ST_S1, ST_S2}) && !IOWE) ||
        (state_d inside {ST_S3, ST_S4, ST_WAIT})) begin
      nlds_d = !IOLDS;
      nuds_d = !IOUDS;
    end
    if (IOWE && (state_d inside {ST_S1, ST_S2, ST_S3, ST_S4, ST_WAIT, ST_TERM})) begin
      ndoutoe_d = 1'b0;
    end
    if (state_d inside {ST_S4, ST_WAIT}) begin
      ndinle_d = 1'b0;
    end
  end

  // Sequencer state, request synchronizer and transfer status
  always_ff @(posedge C16M or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      ioreq_q   <= 1'b0;
      ioact_q   <= 1'b0;
      ioerr_q   <= 1'b0;
      adoutle_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ioreq_q   <= IOREQ;
      ioact_q   <= ioact_d;
      ioerr_q   <= ioerr_d;
      adoutle_q <= adoutle_d;
    end
  end

  // Registered bus strobes
  always_ff @(posedge C16M or posedge RST) begin
    if (RST) begin
      nas_q     <= 1'b1;
      nlds_q    <= 1'b1;
      nuds_q    <= 1'b1;
      ndoutoe_q <= 1'b1;
      ndinle_q  <= 1'b1;
    end else begin
      nas_q     <= nas_d;
      nlds_q    <= nlds_d;
      nuds_q    <= nuds_d;
      ndoutoe_q <= ndoutoe_d;
      ndinle_q  <= ndinle_d;
    end
  end

  // C8M divider and the 20-cycle E-clock phase counter
  always_ff @(posedge C16M or posedge RST) begin
    if (RST) begin
      c8m_q  <= 1'b0;
      ecnt_q <= 5'd0;
      e_q    <= 1'b0;
    end else begin
      c8m_q  <= !c8m_q;
      ecnt_q <= ecnt_d;
      e_q    <= (ecnt_d >= E_HIGH);
    end
  end

  // 6800 peripheral handshake: VMA assertion and E-synchronous acknowledge
  always_ff @(posedge C16M or posedge RST) begin
    if (RST) begin
      nvma_q  <= 1'b1;
      etack_q <= 1'b0;
    end else begin
      if (ecnt_q == 5'd0) begin
        nvma_q <= 1'b1;
      end else if ((state_q == ST_WAIT) && !nVPA && (ecnt_q == VMA_E)) begin
        nvma_q <= 1'b0;
      end
      etack_q <= (ecnt_q == ETACK_E) && !nvma_q;
    end
  end

  // Wait-state timeout: paused during a VMA cycle, saturates at the limit
  always_ff @(posedge C16M or posedge RST) begin
    if (RST) begin
      tmo_q <= '0;
    end else if (state_q != ST_WAIT) begin
      tmo_q <= '0;
    end else if (nvma_q && !tmo_hit) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign IOACT    = ioact_q;
  assign IOERR    = ioerr_q;
  assign C8M      = c8m_q;
  assign E        = e_q;
  assign nAS      = nas_q;
  assign nLDS     = nlds_q;
  assign nUDS     = nuds_q;
  assign nVMA     = nvma_q;
  assign nAoutOE  = 1'b0;
  assign nDoutOE  = ndoutoe_q;
  assign nDinLE   = ndinle_q;
  // Address latch may be held open externally through nADLEEN
  assign nADoutLE = !(adoutle_q || !nADLEEN);

endmodule

// File: tb/tb_pds_bus_master.sv
`timescale 1ns/1ps
// tb_pds_bus_master: randomized bus transfers checked cycle by cycle against a
// timeline model that predicts S1 entry, WAIT span and termination arithmetically.
module tb_pds_bus_master;

  localparam int TMO     = 64;
  localparam int BIG     = 1000000000;
  localparam int R_DTACK = 0;
  localparam int R_BERR  = 1;
  localparam int R_BOTH  = 2;
  localparam int R_NONE  = 3;
  localparam int R_VPA   = 4;
  localparam logic [11:0] RESET_VEC = 12'b0000_1111_0111;

  logic C16M = 1'b0;
  logic RST, IOREQ, IOWE, IOLDS, IOUDS, nADLEEN, nDTACK, nVPA, nBERR;
  logic IOACT, IOERR, C8M, E, nAS, nLDS, nUDS, nVMA;
  logic nAoutOE, nDoutOE, nADoutLE, nDinLE;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int req_since, idle0;
  int p_r, p_s, p_w0, p_t, p_resp, p_d;
  bit p_we, p_lds, p_uds, p_err, prev_err;
  int vma_lo, vma_hi;

  pds_bus_master dut (
    .C16M(C16M), .RST(RST),
    .IOREQ(IOREQ), .IOWE(IOWE), .IOLDS(IOLDS), .IOUDS(IOUDS), .nADLEEN(nADLEEN),
    .IOACT(IOACT), .IOERR(IOERR), .C8M(C8M), .E(E),
    .nAS(nAS), .nLDS(nLDS), .nUDS(nUDS), .nVMA(nVMA),
    .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR),
    .nAoutOE(nAoutOE), .nDoutOE(nDoutOE), .nADoutLE(nADoutLE), .nDinLE(nDinLE)
  );

  always #5 C16M = ~C16M;

  initial begin
    #(5_000_000);
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [11:0] dut_vec();
    return {IOACT, IOERR, C8M, E, nAS, nLDS, nUDS, nVMA, nAoutOE, nDoutOE, nADoutLE, nDinLE};
  endfunction

  // Expected outputs for cycle k (values after the k-th clock edge since reset release)
  function automatic logic [11:0] exp_vec(input int k);
    int   ph;  // 0 idle, 1..4 S1..S4, 5 wait, 6 term, 7 rec
    logic act, drv, err, vma_n;
    if (k >= p_s && k < p_w0)      ph = k - p_s + 1;
    else if (k >= p_w0 && k < p_t) ph = 5;
    else if (k == p_t)             ph = 6;
    else if (k == p_t + 1)         ph = 7;
    else                           ph = 0;
    act   = (k >= p_r) && (k < p_t);
    drv   = ((ph == 1 || ph == 2) && !p_we) || (ph >= 3 && ph <= 5);
    err   = (k < p_s) ? prev_err : ((k < p_t) ? 1'b0 : p_err);
    vma_n = !(k >= vma_lo && k <= vma_hi);
    return {act, err, 1'((k % 2) == 1), (k % 20) >= 12,
            !(ph >= 1 && ph <= 5), !(p_lds && drv), !(p_uds && drv), vma_n,
            1'b0, !(p_we && ph >= 1 && ph <= 6), !(act || !nADLEEN), !(ph == 4 || ph == 5)};
  endfunction

  task automatic drive_resp(input int k);
    nDTACK = !((p_resp == R_DTACK || p_resp == R_BOTH) && k >= p_w0 + p_d && k < p_t);
    nBERR  = !((p_resp == R_BERR  || p_resp == R_BOTH) && k >= p_w0 + p_d && k < p_t);
    nVPA   = !(p_resp == R_VPA && k >= p_s && k < p_t);
  endtask

  task automatic model_reset();
    idle0    = 0;
    p_r = BIG; p_s = BIG; p_w0 = BIG; p_t = BIG;
    p_resp   = R_DTACK;
    p_d      = 0;
    p_we = 1'b0; p_lds = 1'b0; p_uds = 1'b0;
    p_err    = 1'b0;
    prev_err = 1'b0;
    vma_lo   = BIG;
    vma_hi   = -1;
  endtask

  task automatic step(input string tag);
    @(posedge C16M);
    cyc++;
    #1;
    check_eq(tag, 32'(dut_vec()), 32'(exp_vec(cyc)));
    drive_resp(cyc);
  endtask

  // Raise (or keep) the request and predict the whole transfer timeline
  task automatic plan_txn(input bit we, input bit lds, input bit uds, input int resp, input int d);
    int c;
    if (!IOREQ) begin
      IOREQ     = 1'b1;
      req_since = cyc;
    end
    IOWE = we; IOLDS = lds; IOUDS = uds;
    prev_err = p_err;
    p_we = we; p_lds = lds; p_uds = uds;
    p_resp = resp;
    p_d    = d;
    p_r  = (req_since + 2 > idle0 + 1) ? req_since + 2 : idle0 + 1;
    p_s  = (p_r % 2 == 1) ? p_r : p_r + 1;
    p_w0 = p_s + 4;
    case (resp)
      R_NONE: p_t = p_w0 + TMO + 1;
      R_VPA: begin
        c = p_w0;
        while (c % 20 != 7) c++;
        p_t    = c + 11;
        vma_lo = c + 1;
        vma_hi = c + 13;
      end
      default: begin
        c = p_w0 + d;
        if (c % 2 == 0) c++;
        p_t = c + 1;
      end
    endcase
    p_err = (resp == R_BERR || resp == R_BOTH || resp == R_NONE);
    idle0 = p_t + 2;
    drive_resp(cyc);
  endtask

  task automatic run_txn(input string tag, input bit we, input bit lds, input bit uds,
                         input int resp, input int d, input bit keep);
    plan_txn(we, lds, uds, resp, d);
    while (cyc < p_t + 2) begin
      step(tag);
      if (cyc == p_t && !keep) IOREQ = 1'b0;
    end
    $display("[TB] txn %s we=%0b lds=%0b uds=%0b resp=%0d d=%0d s1=%0d term=%0d ioerr=%0b",
             tag, we, lds, uds, resp, d, p_s, p_t, p_err);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    repeat (n) step(tag);
  endtask

  initial begin
    int resp, d, gap;
    bit keep;
    RST = 1'b1; IOREQ = 1'b0; IOWE = 1'b0; IOLDS = 1'b0; IOUDS = 1'b0;
    nADLEEN = 1'b1; nDTACK = 1'b1; nVPA = 1'b1; nBERR = 1'b1;
    cyc = 0; req_since = 0;
    model_reset();
    repeat (3) @(posedge C16M);
    #1;
    check_eq("reset_state", 32'(dut_vec()), 32'(RESET_VEC));
    RST = 1'b0;
    cyc = 0;
    check_eq("reset_release", 32'(dut_vec()), 32'(exp_vec(0)));

    // Directed transfers
    idle_cycles("idle0", 3);
    run_txn("rd_dtack", 1'b0, 1'b1, 1'b1, R_DTACK, 3, 1'b0);
    idle_cycles("gap", 2);
    run_txn("wr_lds", 1'b1, 1'b1, 1'b0, R_DTACK, 0, 1'b0);
    idle_cycles("gap", 1);
    run_txn("vpa", 1'b0, 1'b1, 1'b1, R_VPA, 0, 1'b0);
    run_txn("berr_dtack", 1'b1, 1'b0, 1'b1, R_BOTH, 5, 1'b0);
    nADLEEN = 1'b0;
    idle_cycles("adleen_ovr", 3);
    nADLEEN = 1'b1;
    idle_cycles("gap", 1);
    run_txn("berr", 1'b0, 1'b0, 1'b1, R_BERR, 2, 1'b0);
    run_txn("timeout", 1'b0, 1'b1, 1'b1, R_NONE, 0, 1'b0);
    idle_cycles("gap", 2);
    run_txn("b2b_a", 1'b0, 1'b1, 1'b1, R_DTACK, 1, 1'b1);
    run_txn("b2b_b", 1'b1, 1'b1, 1'b1, R_VPA, 0, 1'b1);
    run_txn("b2b_c", 1'b0, 1'b1, 1'b0, R_NONE, 0, 1'b0);
    idle_cycles("gap", 2);

    // Reset pulse in the middle of a WAIT state with the request held high
    plan_txn(1'b1, 1'b1, 1'b1, R_NONE, 0);
    while (cyc < p_w0 + 3) step("pre_rst");
    #2;
    RST = 1'b1;
    #1;
    check_eq("rst_async", 32'(dut_vec()), 32'(RESET_VEC));
    @(posedge C16M);
    #1;
    check_eq("rst_hold", 32'(dut_vec()), 32'(RESET_VEC));
    RST = 1'b0;
    cyc = 0;
    model_reset();
    req_since = 0;
    drive_resp(0);
    check_eq("rst_release2", 32'(dut_vec()), 32'(exp_vec(0)));
    run_txn("post_rst", 1'b0, 1'b1, 1'b1, R_DTACK, 2, 1'b0);
    idle_cycles("gap", 1);

    // Randomized transfers
    for (int i = 0; i < 25; i++) begin
      resp = $urandom_range(0, 4);
      d    = $urandom_range(0, 12);
      keep = ($urandom_range(0, 2) == 0) && (i != 24);
      run_txn("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), resp, d, keep);
      if (!keep) begin
        gap = $urandom_range(0, 5);
        if (gap > 0) idle_cycles("rand_gap", gap);
      end
    end
    idle_cycles("tail", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
